// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - two-stage pipelined carry-lookahead add/sub with signed saturation and ALU flags
module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int H  = WIDTH / 2;
  localparam int NG = H / 4;

  // Half-width adder: 4-bit lookahead groups; group carries come from the
  // group P/G chain, never from a neighbouring group's bit carries.
  function automatic logic [H:0] cla_half(input logic [H-1:0] a, input logic [H-1:0] b,
                                          input logic cin);
    logic [H-1:0] p, g, c;
    logic [NG:0]  gc;
    logic         gp, gg;
    p = a ^ b;
    g = a & b;
    c = '0;
    gc = '0;
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gp = &p[4*j +: 4];
      gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      gc[j+1]  = gg | (gp & gc[j]);
    end
    return {gc[NG], p ^ c};
  endfunction

  logic [WIDTH-1:0] bx;
  logic [H-1:0]     sum_lo, sum_hi;
  logic             c_mid, c_out;

  logic             s1_valid;
  logic [H-1:0]     s1_sum_lo, s1_a_hi, s1_bx_hi;
  logic             s1_c_mid, s1_sat;

  logic             s2_adv;
  logic             ovf;
  logic [WIDTH-1:0] sat_val, s_next;

  assign bx = mode[0] ? ~B : B;
  assign {c_mid, sum_lo} = cla_half(A[H-1:0], bx[H-1:0], mode[0]);
  assign {c_out, sum_hi} = cla_half(s1_a_hi, s1_bx_hi, s1_c_mid);

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = rst || !s1_valid || s2_adv;

  assign ovf     = (s1_a_hi[H-1] == s1_bx_hi[H-1]) && (sum_hi[H-1] != s1_a_hi[H-1]);
  assign sat_val = s1_a_hi[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign s_next  = (s1_sat && ovf) ? sat_val : {sum_hi, s1_sum_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum_lo <= '0;
      s1_a_hi   <= '0;
      s1_bx_hi  <= '0;
      s1_c_mid  <= 1'b0;
      s1_sat    <= 1'b0;
      out_valid <= 1'b0;
      S         <= '0;
      C         <= 1'b0;
      V         <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      // in_ready here implies stage 1 is empty or moving on this edge
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum_lo <= sum_lo;
          s1_c_mid  <= c_mid;
          s1_a_hi   <= A[WIDTH-1:H];
          s1_bx_hi  <= bx[WIDTH-1:H];
          s1_sat    <= mode[1];
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        S         <= s_next;
        C         <= c_out;
        V         <= ovf;
        N         <= s_next[WIDTH-1];
        Z         <= (s_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - directed-vector bench for cla_addsub_pipe at WIDTH=16 and WIDTH=32
module tb_cla_addsub_pipe;

  logic clk, rst;

  logic        iv16, ir16, ov16, or16, c16, v16, n16, z16;
  logic [15:0] a16, b16, s16;
  logic [1:0]  m16;

  logic        iv32, ir32, ov32, or32, c32, v32, n32, z32;
  logic [31:0] a32, b32, s32;
  logic [1:0]  m32;

  int tests, fails;

  cla_addsub_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16), .mode(m16),
    .out_valid(ov16), .out_ready(or16), .S(s16), .C(c16), .V(v16), .N(n16), .Z(z16)
  );

  cla_addsub_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32), .mode(m32),
    .out_valid(ov32), .out_ready(or32), .S(s32), .C(c32), .V(v32), .N(n32), .Z(z32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({ov16, s16, c16, v16, n16, z16, ir16} !== {1'b0, 16'h0000, 4'b0000, 1'b1}) begin
      fails++;
      $display("FAIL reset16: got valid=%b S=%h CVNZ=%b%b%b%b in_ready=%b, exp valid=0 S=0000 CVNZ=0000 in_ready=1",
               ov16, s16, c16, v16, n16, z16, ir16);
    end
    tests++;
    if ({ov32, s32, c32, v32, n32, z32, ir32} !== {1'b0, 32'h0, 4'b0000, 1'b1}) begin
      fails++;
      $display("FAIL reset32: got valid=%b S=%h CVNZ=%b%b%b%b in_ready=%b, exp valid=0 S=00000000 CVNZ=0000 in_ready=1",
               ov32, s32, c32, v32, n32, z32, ir32);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_arith16();
    logic [15:0] av[10], bv[10], sv[10];
    logic [1:0]  mv[10];
    logic [3:0]  fv[10];
    logic        mid;
    av = '{16'h00FF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
    bv = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h0005, 16'hFFFF, 16'h0100};
    mv = '{2'b00,    2'b00,    2'b10,    2'b01,    2'b11,    2'b00,    2'b11,    2'b01,    2'b10,    2'b10};
    sv = '{16'h0100, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h8000, 16'h1334};
    fv = '{4'b0000,  4'b0110,  4'b0100,  4'b0010,  4'b1110,  4'b1001,  4'b0100,  4'b1001,  4'b1110,  4'b0000};
    or16 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iv16 = 1'b1; a16 = av[i]; b16 = bv[i]; m16 = mv[i];
      tick();
      mid = ov16;
      iv16 = 1'b0;
      tick();
      tests++;
      if ({mid, ov16, s16, c16, v16, n16, z16} !== {1'b0, 1'b1, sv[i], fv[i]}) begin
        fails++;
        $display("FAIL arith16[%0d]: got valid(c1,c2)=%b%b S=%h CVNZ=%b%b%b%b, exp valid=01 S=%h CVNZ=%b",
                 i, mid, ov16, s16, c16, v16, n16, z16, sv[i], fv[i]);
      end
    end
  endtask

  task automatic test_arith32();
    logic [31:0] av[6], bv[6], sv[6];
    logic [1:0]  mv[6];
    logic [3:0]  fv[6];
    logic        mid;
    av = '{32'h000000FF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'h0000FFFF};
    bv = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
    mv = '{2'b00,        2'b00,        2'b10,        2'b01,        2'b11,        2'b00};
    sv = '{32'h00000100, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00010000};
    fv = '{4'b0000,      4'b0110,      4'b0100,      4'b0010,      4'b1110,      4'b0000};
    or32 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iv32 = 1'b1; a32 = av[i]; b32 = bv[i]; m32 = mv[i];
      tick();
      mid = ov32;
      iv32 = 1'b0;
      tick();
      tests++;
      if ({mid, ov32, s32, c32, v32, n32, z32} !== {1'b0, 1'b1, sv[i], fv[i]}) begin
        fails++;
        $display("FAIL arith32[%0d]: got valid(c1,c2)=%b%b S=%h CVNZ=%b%b%b%b, exp valid=01 S=%h CVNZ=%b",
                 i, mid, ov32, s32, c32, v32, n32, z32, sv[i], fv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] av[3], bv[3], sv[3];
    logic [1:0]  mv[3];
    logic [3:0]  fv[3];
    av = '{16'h1234, 16'h1000, 16'hFFF0};
    bv = '{16'h1111, 16'h0001, 16'h0020};
    mv = '{2'b00,    2'b01,    2'b00};
    sv = '{16'h2345, 16'h0FFF, 16'h0010};
    fv = '{4'b0000,  4'b1000,  4'b1000};
    or16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv16 = 1'b1; a16 = av[i]; b16 = bv[i]; m16 = mv[i];
      tick();
      if (i > 0) begin
        tests++;
        if ({ov16, s16, c16, v16, n16, z16} !== {1'b1, sv[i-1], fv[i-1]}) begin
          fails++;
          $display("FAIL b2b[%0d]: got valid=%b S=%h CVNZ=%b%b%b%b, exp valid=1 S=%h CVNZ=%b",
                   i - 1, ov16, s16, c16, v16, n16, z16, sv[i-1], fv[i-1]);
        end
      end
    end
    iv16 = 1'b0;
    tick();
    tests++;
    if ({ov16, s16, c16, v16, n16, z16} !== {1'b1, sv[2], fv[2]}) begin
      fails++;
      $display("FAIL b2b[2]: got valid=%b S=%h CVNZ=%b%b%b%b, exp valid=1 S=%h CVNZ=%b",
               ov16, s16, c16, v16, n16, z16, sv[2], fv[2]);
    end
    tick();
    tests++;
    if (ov16 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: got out_valid=%b, exp 0", ov16);
    end
  endtask

  task automatic test_stall();
    logic [15:0] av[3], bv[3], sv[3];
    logic [1:0]  mv[3];
    logic [3:0]  fv[3];
    logic [19:0] got[$];
    int          acc;
    av = '{16'h0001, 16'h0010, 16'h4000};
    bv = '{16'h0002, 16'h0004, 16'h4000};
    mv = '{2'b00,    2'b01,    2'b10};
    sv = '{16'h0003, 16'h000C, 16'h7FFF};
    fv = '{4'b0000,  4'b1000,  4'b0100};
    acc = 0;
    or16 = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      iv16 = 1'b1; a16 = av[acc]; b16 = bv[acc]; m16 = mv[acc];
      if (ir16) acc++;
      tick();
      if (c >= 1) begin
        tests++;
        if ({ov16, s16, c16, v16, n16, z16} !== {1'b1, sv[0], fv[0]}) begin
          fails++;
          $display("FAIL stall_hold[%0d]: got valid=%b S=%h CVNZ=%b%b%b%b, exp valid=1 S=%h CVNZ=%b",
                   c, ov16, s16, c16, v16, n16, z16, sv[0], fv[0]);
        end
      end
    end
    tests++;
    if (acc !== 2 || ir16 !== 1'b0) begin
      fails++;
      $display("FAIL stall_accepts: got accepts=%0d in_ready=%b, exp accepts=2 in_ready=0", acc, ir16);
    end
    or16 = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (acc < 3) begin
        iv16 = 1'b1; a16 = av[acc]; b16 = bv[acc]; m16 = mv[acc];
      end else begin
        iv16 = 1'b0;
      end
      if (ov16) got.push_back({s16, c16, v16, n16, z16});
      if (iv16 && ir16) acc++;
      tick();
    end
    iv16 = 1'b0;
    tests++;
    if (got.size() != 3) begin
      fails++;
      $display("FAIL stall_count: got %0d results, exp 3", got.size());
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (k >= got.size() || got[k] !== {sv[k], fv[k]}) begin
        fails++;
        $display("FAIL stall_order[%0d]: got S/CVNZ=%h, exp %h", k,
                 (k < got.size()) ? got[k] : 20'hxxxxx, {sv[k], fv[k]});
      end
    end
  endtask

  task automatic test_reset_inflight();
    or16 = 1'b0;
    iv16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; m16 = 2'b00;
    tick();
    a16 = 16'h3333; b16 = 16'h0001; m16 = 2'b01;
    tick();
    iv16 = 1'b0;
    tests++;
    if ({ov16, ir16} !== 2'b10) begin
      fails++;
      $display("FAIL full_pipe: got out_valid=%b in_ready=%b, exp 1 0", ov16, ir16);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (ir16 !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_ready: got in_ready=%b during reset, exp 1", ir16);
    end
    tick();
    tests++;
    if ({ov16, s16, c16, v16, n16, z16, ir16} !== {1'b0, 16'h0000, 4'b0000, 1'b1}) begin
      fails++;
      $display("FAIL rst_flush: got valid=%b S=%h CVNZ=%b%b%b%b in_ready=%b, exp valid=0 S=0000 CVNZ=0000 in_ready=1",
               ov16, s16, c16, v16, n16, z16, ir16);
    end
    rst = 1'b0;
    or16 = 1'b1;
    tick();
    tests++;
    if (ov16 !== 1'b0) begin
      fails++;
      $display("FAIL rst_drop: got out_valid=%b after reset release, exp 0", ov16);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; m16 = 2'b00; or16 = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; m32 = 2'b00; or32 = 1'b1;
    test_reset();
    test_arith16();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_arith32();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
